// File: rtl/puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : puf_challenge_sequencer
// Description : Drives LFSR challenges into the arbiter PUF array, repeats each
//               evaluation EVAL_N times, majority-votes the response bits and
//               hands voted responses out over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_sequencer #(
  parameter int CHAL_W = 8,
  parameter int RESP_W = 8,
  parameter int EVAL_N = 5,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  input  logic [7:0]        num_chal,
  output logic [CHAL_W-1:0] chal_out,
  output logic              puf_pulse,
  input  logic [RESP_W-1:0] puf_resp,
  output logic [RESP_W-1:0] resp_data,
  output logic [RESP_W-1:0] resp_unstable,
  output logic [CHAL_W-1:0] resp_chal,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(EVAL_N + 1);
  localparam int PW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_FIRE   = 3'd2,
    S_SAMPLE = 3'd3,
    S_RESULT = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_phase;
  logic [CW-1:0]      r_eval;
  logic [7:0]         r_remaining;
  logic [CHAL_W-1:0]  r_chal;
  logic               r_pulse;
  logic [RESP_W-1:0]  r_resp_data;
  logic [RESP_W-1:0]  r_resp_unstable;
  logic [CHAL_W-1:0]  r_resp_chal;
  logic               r_resp_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_null;
  logic               w_sample;
  logic               w_result;
  logic               w_hs;
  logic               w_phase_last;
  logic               w_eval_last;
  logic               w_last_chal;
  logic [CHAL_W-1:0]  w_seed;
  logic [CHAL_W-1:0]  w_lfsr;
  logic [RESP_W-1:0]  w_maj;
  logic [RESP_W-1:0]  w_unst;

  assign w_phase_last = (r_phase == PW'(SETTLE - 1));
  assign w_eval_last  = (r_eval == CW'(EVAL_N - 1));
  assign w_last_chal  = (r_remaining == 8'd1);
  assign w_seed       = (seed == '0) ? CHAL_W'(1) : seed;
  // Taps x^8+x^6+x^5+x^4+1 expressed relative to the MSB of an 8-bit chain
  assign w_lfsr       = {r_chal[CHAL_W-2:0],
                         r_chal[CHAL_W-1] ^ r_chal[CHAL_W-3] ^ r_chal[CHAL_W-4] ^ r_chal[CHAL_W-5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_null   = 1'b0;
    w_sample = 1'b0;
    w_result = 1'b0;
    w_hs     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_chal == 8'd0) begin
            w_null = 1'b1;
          end else begin
            w_load = 1'b1;
            w_next = S_ARM;
          end
        end
      end
      S_ARM:    if (w_phase_last) w_next = S_FIRE;
      S_FIRE:   if (w_phase_last) w_next = S_SAMPLE;
      S_SAMPLE: begin
        w_sample = 1'b1;
        w_next   = w_eval_last ? S_RESULT : S_ARM;
      end
      S_RESULT: begin
        w_result = 1'b1;
        w_next   = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (resp_ready) begin
          w_hs   = 1'b1;
          w_next = w_last_chal ? S_IDLE : S_ARM;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  genvar b;
  generate
    for (b = 0; b < RESP_W; b++) begin : g_bit
      logic [CW-1:0] r_ones;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_ones <= '0;
        else if (w_load || w_hs) r_ones <= '0;
        else if (w_sample)       r_ones <= r_ones + CW'(puf_resp[b]);
      end
      assign w_maj[b]  = (r_ones > CW'(EVAL_N / 2));
      assign w_unst[b] = (r_ones != '0) && (r_ones != CW'(EVAL_N));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase         <= '0;
      r_eval          <= '0;
      r_remaining     <= '0;
      r_chal          <= '0;
      r_pulse         <= 1'b0;
      r_resp_data     <= '0;
      r_resp_unstable <= '0;
      r_resp_chal     <= '0;
      r_resp_valid    <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      if ((r_state == S_ARM) || (r_state == S_FIRE))
        r_phase <= w_phase_last ? '0 : r_phase + PW'(1);
      else
        r_phase <= '0;

      if (w_load || w_hs)             r_eval <= '0;
      else if (w_sample && !w_eval_last) r_eval <= r_eval + CW'(1);

      // Pulse is derived from the next state so it is a clean flop output
      r_pulse <= (w_next == S_FIRE) || (w_next == S_SAMPLE);
      r_done  <= w_null || (w_hs && w_last_chal);

      if (w_load) begin
        r_chal      <= w_seed;
        r_remaining <= num_chal;
        r_busy      <= 1'b1;
      end else if (w_hs) begin
        r_chal       <= w_lfsr;
        r_remaining  <= r_remaining - 8'd1;
        r_resp_valid <= 1'b0;
        if (w_last_chal) r_busy <= 1'b0;
      end

      if (w_result) begin
        r_resp_data     <= w_maj;
        r_resp_unstable <= w_unst;
        r_resp_chal     <= r_chal;
        r_resp_valid    <= 1'b1;
      end
    end
  end

  assign chal_out      = r_chal;
  assign puf_pulse     = r_pulse;
  assign resp_data     = r_resp_data;
  assign resp_unstable = r_resp_unstable;
  assign resp_chal     = r_resp_chal;
  assign resp_valid    = r_resp_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Initiator-side controller for the 8-bit arbiter PUF array. It generates challenges from an LFSR and drives the challenge bus and launch pulse. It evaluates each challenge EVAL_N times and majority-votes the 8 response bits, flagging unstable bits. Each voted response is delivered with its challenge over a valid/ready handshake. It sits between the top-level control I/O and the arbiterpuf instance, replacing the raw clock-as-pulse connection.

Parameters:
CHAL_W, 8, challenge width (matches PUF chain length)
RESP_W, 8, response width (number of PUF instances)
EVAL_N, 5, evaluations per challenge; must be odd and >= 1
SETTLE, 4, cycles each pulse phase (low, then high) is held; >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
seed  input  CHAL_W  first challenge; 0 is replaced by 1
num_chal  input  8  number of challenges in the run
chal_out  output  CHAL_W  challenge to PUF, registered
puf_pulse  output  1  launch pulse to PUF, registered
puf_resp  input  RESP_W  PUF response bits
resp_data  output  RESP_W  majority-voted response
resp_unstable  output  RESP_W  1 = bit disagreed across evaluations
resp_chal  output  CHAL_W  challenge that produced resp_data
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset (async assert, sync deassert at the flops): state IDLE; all outputs 0; counters cleared.
- States: IDLE, ARM, FIRE, SAMPLE, RESULT, OUTPUT.
- IDLE:
  - start=1 with num_chal=0 -> done=1 next cycle; stay IDLE.
  - start=1 with num_chal>0 -> chal_reg <= (seed==0 ? 1 : seed); remaining <= num_chal; busy <= 1; -> ARM.
  - start is ignored in every other state.
- ARM: puf_pulse=0 for SETTLE cycles; chal_out stable -> FIRE.
- FIRE: puf_pulse=1 for SETTLE cycles -> SAMPLE.
- SAMPLE: one cycle with puf_pulse=1.
  - ones_cnt[b] += puf_resp[b] for every bit; counter width clog2(EVAL_N+1).
  - eval_cnt+1 < EVAL_N -> eval_cnt++, ARM; else -> RESULT.
- RESULT: one cycle.
  - resp_data[b] <= (ones_cnt[b] > EVAL_N/2).
  - resp_unstable[b] <= (ones_cnt[b] != 0 && ones_cnt[b] != EVAL_N).
  - resp_chal <= chal_reg; resp_valid <= 1 -> OUTPUT.
- OUTPUT: resp_valid, resp_data, resp_unstable, resp_chal held stable until resp_ready=1. On the handshake cycle:
  - resp_valid <= 0; ones_cnt and eval_cnt cleared; chal_reg <= LFSR next; remaining--.
  - If remaining was 1 -> done=1 for one cycle, busy <= 0, IDLE; else -> ARM.
- LFSR: next = {chal[6:0], chal[7]^chal[5]^chal[4]^chal[3]} (x^8+x^6+x^5+x^4+1, maximal length, never reaches 0).
- Latency: start sampled at edge E0 -> first resp_valid high after edge E0 + EVAL_N*(2*SETTLE+1) + 1; 46 with defaults.
- resp_ready held high: next challenge's ARM starts the cycle after the handshake.
- resp_ready high before resp_valid has no effect.
- puf_pulse and chal_out are glitch-free flop outputs; chal_out never changes while puf_pulse=1.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done pulse; a pending response is discarded.
- num_chal=255 is legal; remaining never wraps.

Test Plan:
- Stable PUF model (resp = chal ^ 8'hA5), seed=0x01, num_chal=4, resp_ready=1 -> resp_chal 01,02,04,08; resp_data A4,A7,A1,AD; resp_unstable=0; done one cycle after 4th handshake; first resp_valid at E0+46.
- seed=0x00, num_chal=1 -> resp_chal=0x01; exactly one response; busy falls with done.
- Noisy model: bit0 reads 1 on evaluations 0,2,4 and 0 on 1,3 -> resp_data[0]=1, resp_unstable[0]=1; bit0 reads 1 only on evaluation 4 -> resp_data[0]=0, resp_unstable[0]=1.
- resp_ready held low 20 cycles after resp_valid -> outputs stable; puf_pulse=0 and chal_out unchanged; next ARM starts the cycle after resp_ready=1.
- num_chal=0 with start -> done pulse next cycle; busy stays 0; no puf_pulse activity. start asserted while busy -> ignored.
- rst_n low during FIRE of 2nd challenge -> all outputs 0 immediately; after release, a new start with seed=0x10 begins cleanly from chal_out=0x10.
